// File: rtl/circ_buf_pkg.sv
// -----------------------------------------------------------------------------
// circ_buf_pkg
// Shared definitions for the circular sample buffer arbiter:
//   - default DATA_W / DEPTH / ADDR_W / MAX_RD_WAIT
//   - read-path FSM state type
//   - pointer wrap-increment and relative-to-physical address helpers
// The helpers are sized with the package ADDR_W, so instances that override
// ADDR_W must keep it equal to the package value.
// -----------------------------------------------------------------------------
package circ_buf_pkg;

    localparam int DATA_W      = 12;
    localparam int DEPTH       = 800;
    localparam int ADDR_W      = 10;
    localparam int MAX_RD_WAIT = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MEM  = 2'd1,
        RD_RESP = 2'd2
    } rd_state_t;

    // Advance a pointer by one, wrapping from depth-1 back to 0.
    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] ptr,
                                                   input int depth);
        return (ptr == ADDR_W'(depth - 1)) ? '0 : ptr + ADDR_W'(1);
    endfunction

    // Relative address (0 = oldest) to physical address. The sum is taken one
    // bit wider so op+rel can exceed depth before the single wrap subtraction.
    function automatic logic [ADDR_W-1:0] rel2phys(input logic [ADDR_W-1:0] op,
                                                   input logic [ADDR_W-1:0] rel,
                                                   input int depth);
        logic [ADDR_W:0] sum;
        sum = {1'b0, op} + {1'b0, rel};
        if (sum >= (ADDR_W+1)'(depth)) begin
            sum = sum - (ADDR_W+1)'(depth);
        end
        return sum[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/circ_buf_if.sv
// -----------------------------------------------------------------------------
// circ_buf_if
// Writer/reader bus of the circular sample buffer.
//   slave  : buffer side (circ_buf_arbiter)
//   master : ADC writer + display/DSP reader side
// Writer : wr_valid, wr_data -> wr_ready, wr_drop
// Reader : rd_req, rd_rel_addr -> rd_ready, rd_valid, rd_data, rd_oor
// Status : fill_cnt, ovf_count
// -----------------------------------------------------------------------------
interface circ_buf_if #(
    parameter int DATA_W = circ_buf_pkg::DATA_W,
    parameter int ADDR_W = circ_buf_pkg::ADDR_W
) ();

    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              wr_drop;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_rel_addr;
    logic              rd_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_oor;
    logic [ADDR_W:0]   fill_cnt;
    logic [15:0]       ovf_count;

    modport slave (
        input  wr_valid, wr_data, rd_req, rd_rel_addr,
        output wr_ready, wr_drop, rd_ready, rd_valid, rd_data, rd_oor,
               fill_cnt, ovf_count
    );

    modport master (
        output wr_valid, wr_data, rd_req, rd_rel_addr,
        input  wr_ready, wr_drop, rd_ready, rd_valid, rd_data, rd_oor,
               fill_cnt, ovf_count
    );

endinterface

// File: rtl/circ_buf_sp_ram.sv
// -----------------------------------------------------------------------------
// circ_buf_sp_ram
// Single-port sample RAM, one access per cycle, 1-cycle read latency.
//   clk      : clock
//   i_en     : access enable
//   i_we     : 1 = write i_wdata to i_addr, 0 = read i_addr
//   i_addr   : physical address
//   i_wdata  : write data
//   o_rdata  : read data, valid the cycle after a read access; a write
//              access leaves it unchanged
// -----------------------------------------------------------------------------
module circ_buf_sp_ram #(
    parameter int DATA_W = circ_buf_pkg::DATA_W,
    parameter int DEPTH  = circ_buf_pkg::DEPTH,
    parameter int ADDR_W = circ_buf_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // NOTE: storage arrays get no reset so they map onto RAM macros; readers
    // never see an entry before it has been written.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end else begin
                o_rdata <= r_mem[i_addr];
            end
        end
    end

endmodule

// File: rtl/circ_buf_arbiter.sv
// -----------------------------------------------------------------------------
// circ_buf_arbiter
// Owns an 800-entry circular sample buffer in a single-port RAM and shares the
// port between the ADC writer (via a one-deep hold register) and the
// display/DSP reader (relative addressing, 0 = oldest sample).
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : circ_buf_if.slave (write, read and status signals)
// Build option: define OVF_COUNT_EN to count dropped samples on ovf_count
// (saturating); otherwise ovf_count is tied to 0.
// -----------------------------------------------------------------------------
module circ_buf_arbiter #(
    parameter int DATA_W      = circ_buf_pkg::DATA_W,
    parameter int DEPTH       = circ_buf_pkg::DEPTH,
    parameter int ADDR_W      = circ_buf_pkg::ADDR_W,
    parameter int MAX_RD_WAIT = circ_buf_pkg::MAX_RD_WAIT
) (
    input  logic      clk,
    input  logic      rst_n,
    circ_buf_if.slave bus
);

    import circ_buf_pkg::*;

    localparam int WAIT_W = $clog2(MAX_RD_WAIT + 1);

    rd_state_t         r_state, w_state_nxt;
    logic              r_hold_full;
    logic [DATA_W-1:0] r_hold_data;
    logic [ADDR_W-1:0] r_wp, r_op, r_rel;
    logic [ADDR_W:0]   r_fill;
    logic              r_rd_pend;
    logic [WAIT_W-1:0] r_rd_wait;
    logic              r_rd_valid, r_rd_oor;
    logic [DATA_W-1:0] r_rd_data;

    logic              w_oor, w_rd_grant, w_ram_rd, w_wr_commit;
    logic              w_wr_ready, w_wr_drop, w_rd_ready, w_ram_en;
    logic [ADDR_W-1:0] w_phys, w_ram_addr;
    logic [DATA_W-1:0] w_ram_rdata;

    // Writes win unless a read is pending and has already lost MAX_RD_WAIT times.
    assign w_oor       = ({1'b0, r_rel} >= r_fill);
    assign w_rd_grant  = r_rd_pend && !(r_hold_full && (r_rd_wait < WAIT_W'(MAX_RD_WAIT)));
    assign w_ram_rd    = w_rd_grant && !w_oor;
    // An out-of-range grant never touches the RAM, so a waiting write commits too.
    assign w_wr_commit = r_hold_full && (!w_rd_grant || w_oor);
    // The hold register accepts a new sample in the same cycle it drains.
    assign w_wr_ready  = !r_hold_full || w_wr_commit;
    assign w_wr_drop   = bus.wr_valid && !w_wr_ready;
    // The reader may issue again from the rd_valid cycle onward.
    assign w_rd_ready  = !r_rd_pend && (r_state != RD_MEM);
    assign w_phys      = rel2phys(r_op, r_rel, DEPTH);
    assign w_ram_en    = w_wr_commit || w_ram_rd;
    assign w_ram_addr  = w_wr_commit ? r_wp : w_phys;

    circ_buf_sp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (w_wr_commit),
        .i_addr  (w_ram_addr),
        .i_wdata (r_hold_data),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_ram_rd) w_state_nxt = RD_MEM;
            RD_MEM:  w_state_nxt = RD_RESP;
            RD_RESP: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_full <= 1'b0;
            r_hold_data <= '0;
            r_wp        <= '0;
            r_op        <= '0;
            r_fill      <= '0;
            r_rd_pend   <= 1'b0;
            r_rel       <= '0;
            r_rd_wait   <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_oor    <= 1'b0;
            r_rd_data   <= '0;
        end else begin
            if (bus.wr_valid && w_wr_ready) begin
                r_hold_full <= 1'b1;
                r_hold_data <= bus.wr_data;
            end else if (w_wr_commit) begin
                r_hold_full <= 1'b0;
            end

            // Once full, each commit overwrites the oldest entry.
            if (w_wr_commit) begin
                r_wp <= wrap_inc(r_wp, DEPTH);
                if (r_fill == (ADDR_W+1)'(DEPTH)) begin
                    r_op <= wrap_inc(r_op, DEPTH);
                end else begin
                    r_fill <= r_fill + (ADDR_W+1)'(1);
                end
            end

            if (bus.rd_req && w_rd_ready) begin
                r_rd_pend <= 1'b1;
                r_rel     <= bus.rd_rel_addr;
            end else if (w_rd_grant) begin
                r_rd_pend <= 1'b0;
            end

            if (w_rd_grant) begin
                r_rd_wait <= '0;
            end else if (r_rd_pend && (r_rd_wait < WAIT_W'(MAX_RD_WAIT))) begin
                r_rd_wait <= r_rd_wait + WAIT_W'(1);
            end

            // In-range results leave RD_MEM with the RAM output; out-of-range
            // results answer the cycle after the grant.
            r_rd_valid <= (r_state == RD_MEM) || (w_rd_grant && w_oor);
            r_rd_oor   <= w_rd_grant && w_oor;
            if (r_state == RD_MEM) begin
                r_rd_data <= w_ram_rdata;
            end else if (w_rd_grant && w_oor) begin
                r_rd_data <= '0;
            end
        end
    end

`ifdef OVF_COUNT_EN
    logic [15:0] r_ovf_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_count <= '0;
        end else if (w_wr_drop && (r_ovf_count != 16'hFFFF)) begin
            r_ovf_count <= r_ovf_count + 16'd1;
        end
    end

    assign bus.ovf_count = r_ovf_count;
`else
    assign bus.ovf_count = '0;
`endif

    assign bus.wr_ready = w_wr_ready;
    assign bus.wr_drop  = w_wr_drop;
    assign bus.rd_ready = w_rd_ready;
    assign bus.rd_valid = r_rd_valid;
    assign bus.rd_oor   = r_rd_oor;
    assign bus.rd_data  = r_rd_data;
    assign bus.fill_cnt = r_fill;

endmodule

// File: tb/tb_circ_buf_arbiter.sv
// -----------------------------------------------------------------------------
// tb_circ_buf_arbiter
// Self-checking bench for circ_buf_arbiter. A queue-based reference model
// (oldest sample at the front) is compared with the DUT on every falling
// edge; directed sequences add literal expectations. Honours OVF_COUNT_EN.
// -----------------------------------------------------------------------------
module tb_circ_buf_arbiter;

    import circ_buf_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    circ_buf_if bus ();

    circ_buf_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] m_q[$];
    logic              m_hold_full;
    logic [DATA_W-1:0] m_hold;
    logic              m_pend;
    logic [ADDR_W-1:0] m_rel;
    int                m_wait;
    logic              m_resp_vld;
    logic              m_resp_oor;
    logic [DATA_W-1:0] m_resp_data;
    int                m_resp_due;
    int                m_now;
    int                m_ovf;

    task automatic model_reset();
        m_q.delete();
        m_hold_full = 1'b0;
        m_hold      = '0;
        m_pend      = 1'b0;
        m_rel       = '0;
        m_wait      = 0;
        m_resp_vld  = 1'b0;
        m_resp_oor  = 1'b0;
        m_resp_data = '0;
        m_resp_due  = 0;
        m_now       = 0;
        m_ovf       = 0;
    endtask

    task automatic model_step();
        bit grant, oor, commit, resp_now, exp_wr_ready, exp_rd_ready, exp_drop;
        exp_rd_ready = !m_pend && !(m_resp_vld && (m_resp_due > m_now));
        resp_now     = m_resp_vld && (m_resp_due == m_now);
        grant        = m_pend && (!m_hold_full || (m_wait >= MAX_RD_WAIT));
        oor          = grant && (int'(m_rel) >= m_q.size());
        commit       = m_hold_full && (!grant || oor);
        exp_wr_ready = !m_hold_full || commit;
        exp_drop     = bus.wr_valid && !exp_wr_ready;

        check("wr_ready", bus.wr_ready, exp_wr_ready);
        check("wr_drop", bus.wr_drop, exp_drop);
        check("rd_ready", bus.rd_ready, exp_rd_ready);
        check("rd_valid", bus.rd_valid, resp_now);
        check("fill_cnt", bus.fill_cnt, m_q.size());
        check("ovf_count", bus.ovf_count, m_ovf);
        if (resp_now) begin
            check("rd_oor", bus.rd_oor, m_resp_oor);
            check("rd_data", bus.rd_data, m_resp_data);
            m_resp_vld = 1'b0;
        end

        if (grant) begin
            m_resp_vld  = 1'b1;
            m_resp_oor  = oor;
            m_resp_due  = m_now + (oor ? 1 : 2);
            m_resp_data = oor ? '0 : m_q[m_rel];
            m_pend      = 1'b0;
            m_wait      = 0;
        end else if (m_pend && (m_wait < MAX_RD_WAIT)) begin
            m_wait++;
        end
        if (commit) begin
            m_q.push_back(m_hold);
            if (m_q.size() > DEPTH) void'(m_q.pop_front());
            m_hold_full = 1'b0;
        end
        if (bus.wr_valid && exp_wr_ready) begin
            m_hold_full = 1'b1;
            m_hold      = bus.wr_data;
        end
        if (bus.rd_req && exp_rd_ready) begin
            m_pend = 1'b1;
            m_rel  = bus.rd_rel_addr;
            m_wait = 0;
        end
`ifdef OVF_COUNT_EN
        if (exp_drop && (m_ovf < 32'hFFFF)) m_ovf++;
`endif
        m_now++;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst wr_ready", bus.wr_ready, 1);
            check("rst rd_ready", bus.rd_ready, 1);
            check("rst rd_valid", bus.rd_valid, 0);
            check("rst fill_cnt", bus.fill_cnt, 0);
            check("rst ovf_count", bus.ovf_count, 0);
            model_reset();
        end else begin
            model_step();
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.wr_valid = 1'b0;
        bus.rd_req   = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic write_one(input int v);
        bus.wr_valid = 1'b1;
        bus.wr_data  = DATA_W'(v);
        tick();
        bus.wr_valid = 1'b0;
    endtask

    task automatic do_read(input int rel, input int exp_data, input bit exp_oor,
                           input int exp_lat, input string name);
        int i;
        bit got;
        i = 0;
        while (!bus.rd_ready && (i < 20)) begin
            tick();
            i++;
        end
        check({name, " rd_ready"}, bus.rd_ready, 1);
        bus.rd_req      = 1'b1;
        bus.rd_rel_addr = ADDR_W'(rel);
        tick();
        bus.rd_req = 1'b0;
        got = 1'b0;
        for (i = 0; i < 20; i++) begin
            if (bus.rd_valid) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        check({name, " rd_valid seen"}, got, 1);
        if (got) begin
            check({name, " latency"}, i, exp_lat);
            check({name, " rd_oor"}, bus.rd_oor, exp_oor);
            check({name, " rd_data"}, bus.rd_data, exp_data);
        end
    endtask

    // ---------------- test sequence ----------------
    int drops;
    int valid_at;
    int seen;
    int wr_pct;
    int exp_ovf;

    initial begin
        n_checks = 0;
        n_errors = 0;
        bus.wr_valid    = 1'b0;
        bus.wr_data     = '0;
        bus.rd_req      = 1'b0;
        bus.rd_rel_addr = '0;
        rst_n           = 1'b0;
        repeat (3) tick();
        check("reset wr_ready", bus.wr_ready, 1);
        check("reset rd_ready", bus.rd_ready, 1);
        check("reset fill_cnt", bus.fill_cnt, 0);
        rst_n = 1'b1;
        tick();

        // 1: five spaced writes, in-range and out-of-range reads
        for (int v = 1; v <= 5; v++) begin
            write_one(v);
            tick();
            tick();
        end
        check("t1 fill_cnt", bus.fill_cnt, 5);
        for (int r = 0; r < 5; r++) do_read(r, r + 1, 1'b0, 2, $sformatf("t1 rel%0d", r));
        do_read(5, 0, 1'b1, 1, "t1 rel5 oor");

        // 2: wrap the buffer with 803 back-to-back writes
        apply_reset();
        for (int v = 0; v < 803; v++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = DATA_W'(v);
            tick();
        end
        bus.wr_valid = 1'b0;
        tick();
        tick();
        check("t2 fill_cnt", bus.fill_cnt, DEPTH);
        do_read(0, 3, 1'b0, 2, "t2 rel0");
        do_read(799, 802, 1'b0, 2, "t2 rel799");

        // 4: write committed during the response cycle of a read of that slot
        tick();
        bus.rd_req      = 1'b1;
        bus.rd_rel_addr = '0;
        tick();
        bus.rd_req = 1'b0;
        tick();
        bus.wr_valid = 1'b1;
        bus.wr_data  = 12'hABC;
        tick();
        bus.wr_valid = 1'b0;
        check("t4 rd_valid", bus.rd_valid, 1);
        check("t4 rd_data", bus.rd_data, 3);
        check("t4 wr_ready", bus.wr_ready, 1);
        tick();
        tick();
        check("t4 fill_cnt", bus.fill_cnt, DEPTH);
        do_read(799, 12'hABC, 1'b0, 2, "t4 rel799");
        do_read(0, 4, 1'b0, 2, "t4 rel0");

        // 3 / 6: continuous writer against a read
        tick();
        drops    = 0;
        valid_at = -1;
        for (int k = 0; k < 14; k++) begin
            bus.wr_valid    = 1'b1;
            bus.wr_data     = DATA_W'(k + 100);
            bus.rd_req      = (k == 2);
            bus.rd_rel_addr = ADDR_W'(10);
            #1;
            if (bus.wr_drop) drops++;
            if (bus.rd_valid && (valid_at < 0)) valid_at = k;
            tick();
        end
        bus.wr_valid = 1'b0;
        bus.rd_req   = 1'b0;
        tick();
        tick();
        check("t3 drops", drops, 1);
        check("t3 rd_valid cycle", valid_at, 9);
`ifdef OVF_COUNT_EN
        exp_ovf = 1;
`else
        exp_ovf = 0;
`endif
        check("t3 ovf_count", bus.ovf_count, exp_ovf);

        // 5: reset while the read sits in RD_MEM
        tick();
        check("t5 rd_ready", bus.rd_ready, 1);
        bus.rd_req      = 1'b1;
        bus.rd_rel_addr = ADDR_W'(5);
        tick();
        bus.rd_req = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t5 rd_valid", bus.rd_valid, 0);
        check("t5 wr_ready", bus.wr_ready, 1);
        check("t5 rd_ready", bus.rd_ready, 1);
        check("t5 fill_cnt", bus.fill_cnt, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (4) begin
            if (bus.rd_valid) seen++;
            tick();
        end
        check("t5 no rd_valid", seen, 0);

        // random traffic, alternating light and heavy write phases
        for (int c = 0; c < 4000; c++) begin
            wr_pct = (((c / 500) % 2) == 1) ? 95 : 40;
            bus.wr_valid    = ($urandom_range(0, 99) < wr_pct);
            bus.wr_data     = DATA_W'($urandom);
            bus.rd_req      = ($urandom_range(0, 99) < 30);
            bus.rd_rel_addr = ADDR_W'($urandom_range(0, DEPTH + 40));
            tick();
        end
        bus.wr_valid = 1'b0;
        bus.rd_req   = 1'b0;
        repeat (10) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
